// File: rtl/freq_selector_param_pkg.sv
// Shared helpers for the parametrised frequency selector: reload value and
// period length as functions of counter width, select width and select value.
package freq_selector_param_pkg;

    // Reload value for select s: s placed in the top SEL_W bits of the counter.
    function automatic int unsigned loadv(input int unsigned cnt_w,
                                          input int unsigned sel_w,
                                          input int unsigned s);
        return s << (cnt_w - sel_w);
    endfunction

    // Ticks are this many RO_Clk cycles apart while select s is in force.
    function automatic int unsigned period(input int unsigned cnt_w,
                                           input int unsigned sel_w,
                                           input int unsigned s);
        return (32'd1 << cnt_w) - loadv(cnt_w, sel_w, s);
    endfunction

endpackage

// File: rtl/freq_selector_param_sel_shadow_reg.sv
// Shadow select register: holds a queued select until the next period
// boundary and picks the select that the reload will use.
module sel_shadow_reg #(
    parameter int SEL_W = 3
) (
    input  logic             RO_Clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [SEL_W-1:0] SW,
    input  logic             sel_wr,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             tc,
    input  logic [SEL_W-1:0] sel_active,
    output logic [SEL_W-1:0] next_sel,
    output logic             pending
);
    logic [SEL_W-1:0] shadow;

    // A write in the boundary cycle is consumed directly; otherwise the
    // queued value wins over the select currently in force.
    always_comb begin
        next_sel = sel_active;
        if (sel_wr)       next_sel = sel_req;
        else if (pending) next_sel = shadow;
    end

    // ld and tc both retire any queued value; a lone sel_wr queues (last wins).
    always_ff @(posedge RO_Clk) begin
        if (rst) begin
            shadow  <= '0;
            pending <= 1'b0;
        end else if (ld) begin
            shadow  <= SW;
            pending <= 1'b0;
        end else if (tc) begin
            pending <= 1'b0;
        end else if (sel_wr) begin
            shadow  <= sel_req;
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/freq_selector_param.sv
// Programmable divider of RO_Clk: ticks clk_to_wg once per period, toggles
// sq_out on every tick, and swaps the select only at period boundaries.
module freq_selector_param
    import freq_selector_param_pkg::*;
#(
    parameter int CNT_W = 9,
    parameter int SEL_W = 3
) (
    input  logic             RO_Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [SEL_W-1:0] SW,
    input  logic             sel_wr,
    input  logic [SEL_W-1:0] sel_req,
    output logic             clk_to_wg,
    output logic             sq_out,
    output logic [CNT_W-1:0] count,
    output logic [SEL_W-1:0] sel_active,
    output logic             pending
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic             tc;
    logic [SEL_W-1:0] next_sel;

    // Terminal count only counts while enabled; depends on state and en only.
    assign tc        = en && (count == MAX);
    assign clk_to_wg = tc;

    sel_shadow_reg #(.SEL_W(SEL_W)) u_shadow (
        .RO_Clk     (RO_Clk),
        .rst        (rst),
        .ld         (ld),
        .SW         (SW),
        .sel_wr     (sel_wr),
        .sel_req    (sel_req),
        .tc         (tc),
        .sel_active (sel_active),
        .next_sel   (next_sel),
        .pending    (pending)
    );

    // Counter, active select and square output: rst > ld > reload > increment.
    always_ff @(posedge RO_Clk) begin
        if (rst) begin
            count      <= '0;
            sel_active <= '0;
            sq_out     <= 1'b0;
        end else if (ld) begin
            count      <= CNT_W'(loadv(CNT_W, SEL_W, 32'(SW)));
            sel_active <= SW;
        end else if (tc) begin
            count      <= CNT_W'(loadv(CNT_W, SEL_W, 32'(next_sel)));
            sel_active <= next_sel;
            sq_out     <= ~sq_out;
        end else if (en) begin
            count      <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_freq_selector_param.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a
// period-based model and queues them; the monitor compares on negedge.
module tb_freq_selector_param;
    import freq_selector_param_pkg::*;

    localparam int CNT_W = 9;
    localparam int SEL_W = 3;
    localparam int TOP   = (1 << CNT_W) - 1;

    logic             RO_Clk = 1'b0;
    logic             rst = 1'b1, en = 1'b0, ld = 1'b0, sel_wr = 1'b0;
    logic [SEL_W-1:0] SW = '0, sel_req = '0;
    logic             clk_to_wg, sq_out, pending;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] sel_active;

    freq_selector_param #(.CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .RO_Clk     (RO_Clk),
        .rst        (rst),
        .en         (en),
        .ld         (ld),
        .SW         (SW),
        .sel_wr     (sel_wr),
        .sel_req    (sel_req),
        .clk_to_wg  (clk_to_wg),
        .sq_out     (sq_out),
        .count      (count),
        .sel_active (sel_active),
        .pending    (pending)
    );

    always #5 RO_Clk = ~RO_Clk;

    typedef struct {
        int   cyc;
        logic tick;
        int   cnt;
        int   sel;
        logic pend;
        logic sq;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc_no = 0;

    // Model state: cycles left until the next tick, select in force,
    // queued select (at most one entry), square output level.
    int   m_left, m_sel, m_sq;
    int   m_q[$];

    function automatic int per(input int s);
        return int'(period(CNT_W, SEL_W, s));
    endfunction

    // Apply current inputs: queue this cycle's expected outputs, then step.
    task automatic cyc(input logic r, input logic l, input logic e,
                       input int sw, input logic wr, input int req);
        exp_t x;
        int   nxt;
        rst = r; ld = l; en = e; SW = SEL_W'(sw); sel_wr = wr; sel_req = SEL_W'(req);
        x.cyc  = cyc_no;
        x.tick = e && (m_left == 0);
        x.cnt  = TOP - m_left;
        x.sel  = m_sel;
        x.pend = (m_q.size() != 0);
        x.sq   = m_sq[0];
        q_exp.push_back(x);
        if (r) begin
            m_left = TOP; m_sel = 0; m_sq = 0; m_q.delete();
        end else if (l) begin
            m_left = per(sw) - 1; m_sel = sw; m_q.delete();
        end else if (e && m_left == 0) begin
            nxt = wr ? req : (m_q.size() != 0 ? m_q[0] : m_sel);
            m_left = per(nxt) - 1; m_sel = nxt; m_sq = 1 - m_sq; m_q.delete();
        end else begin
            if (e) m_left--;
            if (wr) begin m_q.delete(); m_q.push_back(req); end
        end
        @(posedge RO_Clk); #1;
        cyc_no++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0);
    endtask

    // Enabled idle cycles until the model reaches count c (bounded).
    task automatic run_to(input int c);
        int k = 0;
        while ((TOP - m_left) != c && k < 4096) begin cyc(0, 0, 1, 0, 0, 0); k++; end
        n_cmp++;
        if (k >= 4096) begin n_bad++; $display("FAIL run_to: count %0d not reached, required %0d", TOP - m_left, c); end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare to queue head.
    initial begin
        exp_t x;
        forever begin
            @(negedge RO_Clk);
            if (q_exp.size() != 0) begin
                x = q_exp.pop_front();
                n_cmp += 5;
                if (clk_to_wg !== x.tick) begin n_bad++; $display("FAIL tick c%0d: got %b required %b", x.cyc, clk_to_wg, x.tick); end
                if (count !== CNT_W'(x.cnt)) begin n_bad++; $display("FAIL count c%0d: got %0d required %0d", x.cyc, count, x.cnt); end
                if (sel_active !== SEL_W'(x.sel)) begin n_bad++; $display("FAIL sel_active c%0d: got %0d required %0d", x.cyc, sel_active, x.sel); end
                if (pending !== x.pend) begin n_bad++; $display("FAIL pending c%0d: got %b required %b", x.cyc, pending, x.pend); end
                if (sq_out !== x.sq) begin n_bad++; $display("FAIL sq_out c%0d: got %b required %b", x.cyc, sq_out, x.sq); end
            end
        end
    end

    initial begin
        // First edge with rst high brings the DUT out of X; model starts there.
        @(posedge RO_Clk); #1;
        m_left = TOP; m_sel = 0; m_sq = 0; m_q.delete();
        cyc(1, 0, 0, 0, 0, 0);
        // Free-running with select 0: 512-cycle period, two ticks.
        run(1030);
        // Load 7: reload 448, 64-cycle period.
        cyc(0, 1, 1, 7, 0, 0);
        run(140);
        // Queue select 2 mid-period; boundary reloads 128.
        run_to(20 + 448);
        cyc(0, 0, 1, 0, 1, 2);
        run_to(TOP); run(10);
        // Write select 4 in the tick cycle itself.
        run_to(TOP);
        cyc(0, 0, 1, 0, 1, 4);
        // Freeze at count 500 for 10 cycles, with a write while frozen.
        run_to(500);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, i == 4, 6);
        run(300);
        // ld with simultaneous sel_wr, then rst mid-period at 300.
        cyc(0, 1, 1, 3, 1, 5);
        run_to(300);
        cyc(1, 0, 1, 0, 0, 0);
        run(5);
        // Randomised phase.
        for (int i = 0; i < 6000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 8, int'($urandom_range(0, 7)),
                $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)));
        @(negedge RO_Clk); @(negedge RO_Clk);
        n_cmp++;
        if (q_exp.size() != 0) begin n_bad++; $display("FAIL drain: %0d left, required 0", q_exp.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
